// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard clock,
// deserializes 11-bit frames, and decodes E0/F0 prefixes into press/release
// events for the game mover.
// The release pulse is named key_release because "release" is a reserved
// word in SystemVerilog.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start bit (data=0 on a filtered falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the odd-parity bit
// STOP   | sampling the stop bit, then accepting or rejecting the byte
module ps2_keyboard_rx #(
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       press,
   output logic       key_release,
   output logic       extended,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int FW = (FILTER  > 1) ? $clog2(FILTER)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [FW-1:0] FILT_TC = FW'(FILTER - 1);
   localparam logic [TW-1:0] TO_TC   = TW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] to_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_err;
   logic          pend_brk, pend_ext;
   logic          filt_flip, fall;
   logic          byte_ok, err_now, to_hit;

   // Two-flop synchronizers; both lines idle high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // The filtered clock flips on the FILTER-th consecutive cycle of disagreement.
   assign filt_flip = (clk_s2 != clk_filt) && (filt_cnt == FILT_TC);
   assign fall      = filt_flip && clk_filt;

   // Glitch filter on the synchronized keyboard clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_flip) begin
         clk_filt <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic plus byte-accept / error strobes for this cycle.
   always_comb begin
      state_nxt = state;
      byte_ok   = 1'b0;
      err_now   = 1'b0;
      to_hit    = (state != IDLE) && !fall && (to_cnt == TO_TC);
      unique case (state)
         IDLE: if (fall) begin
            if (dat_s2) err_now   = 1'b1;
            else        state_nxt = DATA;
         end
         DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
         PARITY: if (fall) state_nxt = STOP;
         STOP: if (fall) begin
            state_nxt = IDLE;
            if (dat_s2 && !par_err) byte_ok = 1'b1;
            else                    err_now = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (to_hit) begin
         state_nxt = IDLE;
         err_now   = 1'b1;
      end
   end

   // Frame datapath: bit counter, shift register, parity check, timeout counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         shift   <= '0;
         par_err <= 1'b0;
         to_cnt  <= '0;
      end else begin
         if (state_nxt == IDLE || fall) to_cnt <= '0;
         else                           to_cnt <= to_cnt + 1'b1;
         if (to_hit) begin
            bit_cnt <= '0;
         end else if (fall) begin
            unique case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_err <= ~(^{shift, dat_s2});
               default: ;
            endcase
         end
      end
   end

   // Scancode decode: prefixes arm pending flags, other bytes emit events.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         code        <= 8'h00;
         press       <= 1'b0;
         key_release <= 1'b0;
         extended    <= 1'b0;
         frame_err   <= 1'b0;
         pend_brk    <= 1'b0;
         pend_ext    <= 1'b0;
      end else begin
         press       <= 1'b0;
         key_release <= 1'b0;
         frame_err   <= err_now;
         if (err_now) begin
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
         end else if (byte_ok) begin
            if (shift == 8'hE0) begin
               pend_ext <= 1'b1;
            end else if (shift == 8'hF0) begin
               pend_brk <= 1'b1;
            end else begin
               extended <= pend_ext;
               pend_brk <= 1'b0;
               pend_ext <= 1'b0;
               if (pend_brk) begin
                  key_release <= 1'b1;
               end else begin
                  code  <= shift;
                  press <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames push expected
// events; a monitor pops and compares on every output pulse.
module tb_ps2_keyboard_rx;

   localparam int FILTER  = 4;
   localparam int TIMEOUT = 300;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_ERR   = 2;

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       ext;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] code;
   logic       press, key_release, extended, frame_err;

   ev_t exp_q[$];
   int  n_total = 0;
   int  n_pass  = 0;
   logic prev_press = 1'b0, prev_rel = 1'b0, prev_err = 1'b0;

   ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .code        (code),
      .press       (press),
      .key_release (key_release),
      .extended    (extended),
      .frame_err   (frame_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   task automatic push(input int kind, input logic [7:0] c, input logic e);
      ev_t ev;
      ev.kind = kind;
      ev.code = c;
      ev.ext  = e;
      exp_q.push_back(ev);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
   endtask

   task automatic glitch();
      ps2_clk = 1'b0;
      wait_cyc(FILTER - 1);
      ps2_clk = 1'b1;
      wait_cyc(5);
   endtask

   // Full 11-bit frame; bad_par inverts parity, stop sets the stop bit,
   // glitch_at inserts a short clock glitch before that data bit.
   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic stop, input int glitch_at);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_at) glitch();
         send_bit(b[i]);
      end
      send_bit(~(^b) ^ bad_par);
      send_bit(stop);
      ps2_data = 1'b1;
      wait_cyc(30);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, -1);
   endtask

   // Monitor: every output pulse must match the head of the expected queue.
   always @(negedge clock) begin
      if (reset_n && (press || key_release || frame_err)) begin
         int  kind;
         ev_t ev;
         chk("press_release_overlap", {31'd0, press && key_release}, 32'd0);
         chk("pulse_consecutive",
             {31'd0, (press && prev_press) || (key_release && prev_rel) || (frame_err && prev_err)}, 32'd0);
         kind = press ? K_PRESS : (key_release ? K_REL : K_ERR);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse_kind", kind, 32'hFFFF);
         end else begin
            ev = exp_q.pop_front();
            chk("event_kind", kind, ev.kind);
            chk("event_code", {24'd0, code}, {24'd0, ev.code});
            if (ev.kind != K_ERR) chk("event_extended", {31'd0, extended}, {31'd0, ev.ext});
         end
      end
      prev_press <= press;
      prev_rel   <= key_release;
      prev_err   <= frame_err;
   end

   initial begin
      int budget;
      wait_cyc(3);
      chk("rst_code", {24'd0, code}, 32'h00);
      chk("rst_press", {31'd0, press}, 32'd0);
      chk("rst_release", {31'd0, key_release}, 32'd0);
      chk("rst_extended", {31'd0, extended}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      reset_n = 1'b1;
      wait_cyc(20);

      push(K_PRESS, 8'h6B, 1'b0);            send_byte(8'h6B);
      push(K_REL,   8'h6B, 1'b0);            send_byte(8'hF0); send_byte(8'h74);
      push(K_PRESS, 8'h74, 1'b1);            send_byte(8'hE0); send_byte(8'h74);
      push(K_ERR,   8'h74, 1'b0);            send_frame(8'h6B, 1'b1, 1'b1, -1);
      push(K_PRESS, 8'h1C, 1'b0);            send_byte(8'h1C);
      push(K_PRESS, 8'h1C, 1'b0);            send_byte(8'h1C);
      push(K_REL,   8'h1C, 1'b1);            send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);

      // E0 then a truncated frame: timeout must also drop the pending E0.
      send_byte(8'hE0);
      push(K_ERR, 8'h1C, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_cyc(TIMEOUT + 20);
      push(K_PRESS, 8'h74, 1'b0);            send_byte(8'h74);

      push(K_PRESS, 8'h5A, 1'b0);            send_frame(8'h5A, 1'b0, 1'b1, 3);
      push(K_ERR,   8'h5A, 1'b0);            send_bit(1'b1);
      wait_cyc(20);
      push(K_ERR,   8'h5A, 1'b0);            send_frame(8'h29, 1'b0, 1'b0, -1);
      push(K_PRESS, 8'h29, 1'b0);            send_byte(8'h29);

      // Reset in the middle of a frame: partial byte discarded, no pulse.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      reset_n = 1'b0;
      wait_cyc(2);
      chk("midrst_code", {24'd0, code}, 32'h00);
      chk("midrst_extended", {31'd0, extended}, 32'd0);
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(20);
      push(K_PRESS, 8'h6B, 1'b0);            send_byte(8'h6B);

      budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
         wait_cyc(1);
         budget++;
      end
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("final_code", {24'd0, code}, 32'h6B);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
